countdown_ctrl: RTL and testbench
=================================

Name: countdown_ctrl

Overview:
- Sequencer for the two-digit BCD seconds countdown datapath (00-59).
- Validates and loads the BCD preset, and generates the per-second count-enable strobe from the system clock.
- Handles start/restart, pause/resume and expiry; holds the alarm for a fixed number of seconds.
- Keeps its own shadow copy of the remaining time, which feeds the display path.

Parameters:
- TICK_DIV, 50000000, C_CLK cycles per one-second tick; must be >= 2; benches use 4.
- ALARM_TICKS, 3, number of ticks alarm stays asserted after expiry; must be >= 1.

Ports:
- C_CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- preset  in  8  BCD load value {tens[7:4], ones[3:0]}; sampled only on an accepted start.
- start  in  1  level from debounced button; rising edge = start/restart.
- pause  in  1  level from debounced button; rising edge = pause/resume toggle.
- tick_en  out  1  one-cycle count-enable strobe to the counter datapath; RUN only.
- cnt_load  out  1  one-cycle load strobe to the datapath on every accepted start.
- remain  out  8  BCD remaining time {tens, ones}.
- state  out  2  current FSM state (encoding from package).
- alarm  out  1  high during ALARM.
- err  out  1  one-cycle pulse when a start is rejected.
- busy  out  1  high in RUN or PAUSE.

Behaviour:
- Reset values:
  - Outputs: state=IDLE, remain=8'h00, all strobes, alarm, err and busy = 0.
  - Internal: prescaler=0, alarm counter=0, start/pause history regs = 1.
  - Because history resets to 1, a button held through reset produces no edge.
- Edge detect:
  - rise = in & ~in_q; in_q is registered every cycle.
  - All outputs are registered, so outputs respond at the same clock edge at which the input is first sampled high.
- Preset validity: ones <= 9, tens <= 5, and preset != 8'h00.
- Accepted start (rise of start in any state, valid preset):
  - remain <= preset, prescaler <= 0, alarm counter <= 0, state <= RUN, cnt_load = 1 for one cycle.
- Rejected start (invalid preset):
  - err = 1 for one cycle.
  - state, remain and prescaler are unchanged; no cnt_load is issued.
- IDLE: pause rise is ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - On the cycle it equals TICK_DIV-1, the next edge registers tick_en = 1 together with a BCD decrement of remain.
  - The first tick occurs exactly TICK_DIV cycles after the cnt_load cycle.
- BCD decrement: if ones == 0 then ones <= 9 and tens <= tens-1; else ones <= ones-1.
- Expiry:
  - The tick that takes remain from 8'h01 to 8'h00 also sets state <= ALARM and alarm <= 1 on the same edge.
  - That tick still issues tick_en.
- RUN, pause rise -> PAUSE; prescaler is frozen at its current value.
- PAUSE:
  - No tick_en; remain is held.
  - pause rise -> RUN; the prescaler resumes from its frozen value, so no phase is lost.
- ALARM:
  - The prescaler keeps running, but tick_en stays 0.
  - The alarm counter increments per internal tick; on the ALARM_TICKS-th tick: state <= IDLE, alarm <= 0, remain stays 00.
  - pause rise is ignored.
- Simultaneous start and pause rises: start has priority and pause is discarded. This applies even if the start is rejected.
- RST mid-operation: all registers return to reset values at the next edge; there are no pending strobes afterwards.
- busy = (state == RUN) || (state == PAUSE), registered with state.

Decomposition:
- Shared package countdown_pkg:
  - State encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, ALARM=2'd3.
  - BCD digit limits: ONES_MAX=4'd9, TENS_MAX=4'd5.
- Prescaler width: $clog2(TICK_DIV). Alarm counter width: $clog2(ALARM_TICKS+1).
- One sub-module: btn_edge (registered history, reset value 1, rise output), instantiated for start and pause.
- BCD decrement and FSM stay in the top module.

Test Plan (TICK_DIV=4, ALARM_TICKS=3):
- Reset and held buttons: assert RST for 3 cycles with start=1 held, then release -> all outputs 0, state=0, no cnt_load or err while start remains high.
- Full run: preset=8'h12, start pulse ->
  - cnt_load for 1 cycle, remain=12, state=1, busy=1.
  - tick_en every 4 cycles; remain 11, 10, 09 (borrow), ..., 00 on tick 12.
  - alarm=1 and state=3 on that same edge; alarm high 12 cycles, then state=0, alarm=0.
- Rejection: presets 8'h5A, 8'h60 and 8'h00 with start -> err pulse each, state stays 0, no cnt_load, remain unchanged.
- Pause/resume:
  - preset=8'h05, start; one cycle after the second tick, pause -> state=2, remain=03 held for 20 cycles, no tick_en.
  - pause again -> next tick exactly 3 cycles after the resume edge, remain=02.
- Priority and restart:
  - In RUN at remain=07, start and pause rise in the same cycle with preset=8'h30 -> cnt_load, remain=30, state=1, prescaler restarted.
  - Start during ALARM -> reloads and runs, alarm=0.
- Reset mid-operation: RST asserted in RUN at remain=09 -> next edge all outputs 0, state=0; no tick_en afterwards until a new start.

Source files
------------

// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the BCD seconds countdown sequencer.
//
// Contents:
//   state_t    - FSM state encoding (IDLE, RUN, PAUSE, ALARM)
//   ONES_MAX   - largest legal ones digit
//   TENS_MAX   - largest legal tens digit
//   bcd_valid  - checks that a two-digit BCD preset is loadable
//   bcd_dec    - decrements a two-digit BCD value by one second
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  // A preset of 00 is rejected as well, since it would expire immediately.
  function automatic logic bcd_valid(input logic [7:0] value);
    return (value[3:0] <= ONES_MAX) && (value[7:4] <= TENS_MAX) &&
           (value != 8'h00);
  endfunction

  // Ones digit borrows from tens. Callers never decrement 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] value);
    logic [7:0] result;
    if (value[3:0] == 4'd0) begin
      result = {value[7:4] - 4'd1, ONES_MAX};
    end else begin
      result = {value[7:4], value[3:0] - 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/countdown_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button level.
//
// Ports:
//   C_CLK  in  1  system clock
//   RST    in  1  synchronous active-high reset
//   btn    in  1  debounced button level
//   rise   out 1  high while btn is 1 and was 0 on the previous cycle
//
// The history register resets to 1, so a button held through reset
// never produces an edge when reset is released.
module btn_edge (
  input  logic C_CLK,
  input  logic RST,
  input  logic btn,
  output logic rise
);

  logic btn_q;

  // Previous-cycle copy of the button level.
  always_ff @(posedge C_CLK) begin
    if (RST) begin
      btn_q <= 1'b1;
    end else begin
      btn_q <= btn;
    end
  end

  // Combinational so the sequencer reacts on the same edge that first
  // samples the button high.
  assign rise = btn & ~btn_q;

endmodule

// File: rtl/countdown_ctrl.sv
// Sequencer for a two-digit BCD seconds countdown (00-59).
//
// Ports:
//   C_CLK     in  1  system clock, rising edge
//   RST       in  1  synchronous active-high reset
//   preset    in  8  BCD load value {tens, ones}, sampled on accepted start
//   start     in  1  debounced level, rising edge = start/restart
//   pause     in  1  debounced level, rising edge = pause/resume toggle
//   tick_en   out 1  one-cycle count-enable strobe, RUN only
//   cnt_load  out 1  one-cycle load strobe on every accepted start
//   remain    out 8  BCD remaining time {tens, ones}
//   state     out 2  current FSM state (countdown_pkg::state_t encoding)
//   alarm     out 1  high during ALARM
//   err       out 1  one-cycle pulse when a start is rejected
//   busy      out 1  high in RUN or PAUSE
//
// Parameters:
//   TICK_DIV     C_CLK cycles per one-second tick (>= 2)
//   ALARM_TICKS  ticks the alarm stays asserted after expiry (>= 1)
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_DIV    = 50000000,
  parameter int ALARM_TICKS = 3
) (
  input  logic       C_CLK,
  input  logic       RST,
  input  logic [7:0] preset,
  input  logic       start,
  input  logic       pause,
  output logic       tick_en,
  output logic       cnt_load,
  output logic [7:0] remain,
  output logic [1:0] state,
  output logic       alarm,
  output logic       err,
  output logic       busy
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int ALM_W   = $clog2(ALARM_TICKS + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [ALM_W-1:0]   ALM_LAST   = ALM_W'(ALARM_TICKS - 1);

  state_t             st, st_nxt;
  logic [PRESC_W-1:0] presc, presc_nxt;
  logic [ALM_W-1:0]   alm_cnt, alm_cnt_nxt;
  logic [7:0]         remain_nxt;
  logic               tick_nxt, load_nxt, err_nxt, alarm_nxt, busy_nxt;
  logic               start_rise, pause_rise;

  btn_edge u_start_edge (
    .C_CLK (C_CLK),
    .RST   (RST),
    .btn   (start),
    .rise  (start_rise)
  );

  btn_edge u_pause_edge (
    .C_CLK (C_CLK),
    .RST   (RST),
    .btn   (pause),
    .rise  (pause_rise)
  );

  assign state = st;

  // Register every FSM output so the display and datapath only see
  // glitch-free values that change on the clock edge.
  always_ff @(posedge C_CLK) begin
    if (RST) begin
      st       <= IDLE;
      presc    <= '0;
      alm_cnt  <= '0;
      remain   <= 8'h00;
      tick_en  <= 1'b0;
      cnt_load <= 1'b0;
      err      <= 1'b0;
      alarm    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      st       <= st_nxt;
      presc    <= presc_nxt;
      alm_cnt  <= alm_cnt_nxt;
      remain   <= remain_nxt;
      tick_en  <= tick_nxt;
      cnt_load <= load_nxt;
      err      <= err_nxt;
      alarm    <= alarm_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next-state logic. A start edge outranks everything else, including a
  // simultaneous pause edge, which is dropped even if the start is
  // rejected. The prescaler only advances in RUN and ALARM; in PAUSE it
  // stays frozen so resuming keeps the phase of the current second.
  always_comb begin
    st_nxt      = st;
    presc_nxt   = presc;
    alm_cnt_nxt = alm_cnt;
    remain_nxt  = remain;
    tick_nxt    = 1'b0;
    load_nxt    = 1'b0;
    err_nxt     = 1'b0;
    alarm_nxt   = alarm;

    if (start_rise) begin
      if (bcd_valid(preset)) begin
        st_nxt      = RUN;
        presc_nxt   = '0;
        alm_cnt_nxt = '0;
        remain_nxt  = preset;
        load_nxt    = 1'b1;
        alarm_nxt   = 1'b0;
      end else begin
        err_nxt = 1'b1;
      end
    end else begin
      case (st)
        IDLE: begin
        end
        RUN: begin
          if (pause_rise) begin
            st_nxt = PAUSE;
          end else if (presc == PRESC_LAST) begin
            presc_nxt  = '0;
            tick_nxt   = 1'b1;
            remain_nxt = bcd_dec(remain);
            if (remain == 8'h01) begin
              st_nxt      = ALARM;
              alarm_nxt   = 1'b1;
              alm_cnt_nxt = '0;
            end
          end else begin
            presc_nxt = presc + PRESC_W'(1);
          end
        end
        PAUSE: begin
          if (pause_rise) begin
            st_nxt = RUN;
          end
        end
        ALARM: begin
          if (presc == PRESC_LAST) begin
            presc_nxt = '0;
            if (alm_cnt == ALM_LAST) begin
              st_nxt      = IDLE;
              alarm_nxt   = 1'b0;
              alm_cnt_nxt = '0;
            end else begin
              alm_cnt_nxt = alm_cnt + ALM_W'(1);
            end
          end else begin
            presc_nxt = presc + PRESC_W'(1);
          end
        end
        default: begin
          st_nxt = IDLE;
        end
      endcase
    end

    busy_nxt = (st_nxt == RUN) || (st_nxt == PAUSE);
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed self-checking bench for countdown_ctrl with TICK_DIV=4,
// ALARM_TICKS=3. Inputs change 1 time unit after each rising edge and
// outputs are checked at the same point, well away from the next edge.
module tb_countdown_ctrl;

  logic       C_CLK = 1'b0;
  logic       RST;
  logic [7:0] preset;
  logic       start;
  logic       pause;
  logic       tick_en;
  logic       cnt_load;
  logic [7:0] remain;
  logic [1:0] state;
  logic       alarm;
  logic       err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  countdown_ctrl #(
    .TICK_DIV    (4),
    .ALARM_TICKS (3)
  ) dut (
    .C_CLK    (C_CLK),
    .RST      (RST),
    .preset   (preset),
    .start    (start),
    .pause    (pause),
    .tick_en  (tick_en),
    .cnt_load (cnt_load),
    .remain   (remain),
    .state    (state),
    .alarm    (alarm),
    .err      (err),
    .busy     (busy)
  );

  // 10 time-unit clock.
  always #5 C_CLK = ~C_CLK;

  // Drive all inputs, then advance one rising edge and settle.
  task automatic applyStimulus(input logic r, input logic s, input logic p,
                               input logic [7:0] pre);
    RST    = r;
    start  = s;
    pause  = p;
    preset = pre;
    @(posedge C_CLK);
    #1;
  endtask

  // Single comparison; counts every call and every failure.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed,
             expected);
    end
  endtask

  // Remaining time after each tick of a 12-second run.
  logic [7:0] exp_remain [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                                  8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
  logic [7:0] bad_presets [3] = '{8'h5A, 8'h60, 8'h00};

  initial begin
    RST    = 1'b1;
    start  = 1'b1;
    pause  = 1'b0;
    preset = 8'h12;

    // Reset with start held high.
    $display("[TB] reset with start held");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h12);
    checkOutput("rst_state", 8'(state), 8'h0);
    checkOutput("rst_remain", remain, 8'h00);
    checkOutput("rst_busy", 8'(busy), 8'h0);
    checkOutput("rst_alarm", 8'(alarm), 8'h0);
    checkOutput("rst_tick", 8'(tick_en), 8'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h12);
      checkOutput("held_load", 8'(cnt_load), 8'h0);
      checkOutput("held_err", 8'(err), 8'h0);
      checkOutput("held_state", 8'(state), 8'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h12);

    // Full run from 12 to expiry and alarm hold.
    $display("[TB] full run from 12");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h12);
    checkOutput("run_load", 8'(cnt_load), 8'h1);
    checkOutput("run_remain", remain, 8'h12);
    checkOutput("run_state", 8'(state), 8'h1);
    checkOutput("run_busy", 8'(busy), 8'h1);
    checkOutput("run_tick0", 8'(tick_en), 8'h0);
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < 3; j++) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("run_notick", 8'(tick_en), 8'h0);
        checkOutput("run_noload", 8'(cnt_load), 8'h0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("run_tick", 8'(tick_en), 8'h1);
      checkOutput("run_dec", remain, exp_remain[k]);
      if (k < 11) begin
        checkOutput("run_state_k", 8'(state), 8'h1);
      end else begin
        checkOutput("exp_state", 8'(state), 8'h3);
        checkOutput("exp_alarm", 8'(alarm), 8'h1);
        checkOutput("exp_busy", 8'(busy), 8'h0);
      end
    end
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("alarm_hold", 8'(alarm), 8'h1);
      checkOutput("alarm_state", 8'(state), 8'h3);
      checkOutput("alarm_notick", 8'(tick_en), 8'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("alarm_end_state", 8'(state), 8'h0);
    checkOutput("alarm_end_alarm", 8'(alarm), 8'h0);
    checkOutput("alarm_end_remain", remain, 8'h00);

    // Rejected presets.
    $display("[TB] rejected presets");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, bad_presets[i]);
      checkOutput("rej_err", 8'(err), 8'h1);
      checkOutput("rej_load", 8'(cnt_load), 8'h0);
      checkOutput("rej_state", 8'(state), 8'h0);
      checkOutput("rej_remain", remain, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("rej_err_clr", 8'(err), 8'h0);
    end

    // Pause and resume keep the prescaler phase.
    $display("[TB] pause and resume");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h05);
    checkOutput("pr_load", 8'(cnt_load), 8'h1);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("pr_tick", 8'(tick_en), 8'h1);
    end
    checkOutput("pr_remain", remain, 8'h03);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("pr_paused", 8'(state), 8'h2);
    checkOutput("pr_busy", 8'(busy), 8'h1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("pr_hold_tick", 8'(tick_en), 8'h0);
      checkOutput("pr_hold_remain", remain, 8'h03);
      checkOutput("pr_hold_state", 8'(state), 8'h2);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("pr_resumed", 8'(state), 8'h1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("pr_res_notick", 8'(tick_en), 8'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("pr_res_tick", 8'(tick_en), 8'h1);
    checkOutput("pr_res_remain", remain, 8'h02);

    // Start with simultaneous pause restarts and reloads.
    $display("[TB] start priority and restart");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h08);
    for (int j = 0; j < 4; j++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("pri_remain07", remain, 8'h07);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h30);
    checkOutput("pri_load", 8'(cnt_load), 8'h1);
    checkOutput("pri_remain", remain, 8'h30);
    checkOutput("pri_state", 8'(state), 8'h1);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("pri_notick", 8'(tick_en), 8'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("pri_tick", 8'(tick_en), 8'h1);
    checkOutput("pri_remain29", remain, 8'h29);

    // Restart from ALARM; pause is ignored there.
    $display("[TB] restart from alarm");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01);
    for (int j = 0; j < 4; j++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("ra_state", 8'(state), 8'h3);
    checkOutput("ra_remain", remain, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("ra_pause_ign", 8'(state), 8'h3);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h09);
    checkOutput("ra_load", 8'(cnt_load), 8'h1);
    checkOutput("ra_alarm", 8'(alarm), 8'h0);
    checkOutput("ra_run", 8'(state), 8'h1);
    checkOutput("ra_remain09", remain, 8'h09);

    // Reset in the middle of a run.
    $display("[TB] reset mid-run");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("mr_state", 8'(state), 8'h0);
    checkOutput("mr_remain", remain, 8'h00);
    checkOutput("mr_busy", 8'(busy), 8'h0);
    checkOutput("mr_alarm", 8'(alarm), 8'h0);
    checkOutput("mr_load", 8'(cnt_load), 8'h0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("mr_notick", 8'(tick_en), 8'h0);
      checkOutput("mr_idle", 8'(state), 8'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
